psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
Downstream stage of the convolution controller and PE array. Takes the stream of per-pixel partial sums that the PE array produces for each input channel. Accumulates them across NUM_CHANNEL channels in an internal OFM-sized buffer. On the last channel it applies ReLU, requantises and saturates each pixel, then streams the finished output feature map to the writeback stage over a valid/ready handshake.

Parameters:
DATA_WIDTH, 16, width of the output pixel (signed)
ACC_WIDTH, 36, width of the incoming psum and of the accumulator words (signed)
NUM_CHANNEL, 3, input channels summed per output map
OFM_SIZE, 7, output map is OFM_SIZE x OFM_SIZE pixels
FRAC_BITS, 8, arithmetic right shift applied before the output saturation
RELU_EN, 1, 1 = clamp negative results to 0 before the shift

Ports:
clk1  in  1  sole clock
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a new output map
psum_valid  in  1  psum_in is valid
psum_ready  out  1  block accepts psum_in this cycle
psum_in  in  ACC_WIDTH  signed partial sum, raster order, channel-major
ofm_valid  out  1  ofm_data is valid
ofm_ready  in  1  downstream accepts ofm_data
ofm_data  out  DATA_WIDTH  finished signed output pixel
ofm_last  out  1  marks the final pixel of the map, qualified by ofm_valid
busy  out  1  high from start until done
done  out  1  one-cycle pulse after the last pixel is accepted downstream
channel_cnt  out  4  channel currently being accumulated
pixel_cnt  out  10  pixel index within the current channel, 0..OFM_SIZE^2-1

Behaviour:
- Interface: one clock, clk1. Reset rst_n is synchronous and active-low: it is sampled only on the rising edge of clk1.
- Reset values: every output is 0, the state is IDLE, and all counters are 0.
- Buffer contents are not reset. Channel 0 always overwrites, so stale data is harmless.
- Transfers: an input transfer happens when psum_valid and psum_ready are both high. An output transfer happens when ofm_valid and ofm_ready are both high.

FSM states and transitions:
- IDLE: psum_ready=0, busy=0. start moves the FSM to ACCUM and clears channel_cnt and pixel_cnt.
- ACCUM: busy=1.
  - Channel 0: buf[pixel] <= psum_in.
  - Channels 1..NUM_CHANNEL-2: buf[pixel] <= buf[pixel] + psum_in.
  - Last channel: sum = buf[pixel] + psum_in, sent to the output register.
  - pixel_cnt increments on every input transfer. At OFM_SIZE^2-1 it wraps to 0 and channel_cnt increments.
  - The transfer of the last pixel of the last channel moves the FSM to FLUSH.
- FLUSH: psum_ready=0. Waits until the output register is empty (ofm_valid=0, or it is transferring this cycle), then goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle as done.
- start is ignored outside IDLE.
- NUM_CHANNEL=1: channel 0 is also the last channel, so its psums go straight to the output path.

psum_ready rule:
- In ACCUM on a non-last channel: psum_ready=1.
- In ACCUM on the last channel: psum_ready = !ofm_valid || ofm_ready. The output stage is a single-entry register, so backpressure propagates combinationally to psum_ready.

Arithmetic:
- Accumulator additions saturate at the signed ACC_WIDTH limits and never wrap.
- Output path, in order: ReLU (if RELU_EN), then arithmetic shift right by FRAC_BITS, then saturate to the signed DATA_WIDTH range (-32768..32767 at the defaults).

Latency and output register:
- A last-channel input transfer in cycle N gives ofm_valid=1 in cycle N+1.
- ofm_data and ofm_last stay stable while ofm_valid=1 and ofm_ready=0.
- ofm_last=1 only on pixel OFM_SIZE^2-1.

Reset mid-operation: the FSM returns to IDLE on the next edge and clears ofm_valid. Any in-flight output is dropped, and no done pulse is issued.

Decomposition:
- Shared package eyeriss_pkg holds:
  - the FSM state encoding (IDLE, ACCUM, FLUSH, DONE);
  - the saturating-add and saturate-to-width functions;
  - the OFM_PIXELS = OFM_SIZE*OFM_SIZE constant.
- One sub-module, psum_buffer: an OFM_PIXELS x ACC_WIDTH register array with a combinational read port and a synchronous write port, addressed by pixel_cnt.

Test Plan:
- Defaults, psum_in=256 for every pixel on all 3 channels, ofm_ready=1 -> 49 outputs, each ofm_data=3, ofm_last on the 49th, done pulses once, busy falls with done.
- Channel psums -1024, -1024, 1024 with RELU_EN=1 -> ofm_data=0 on every pixel. With RELU_EN=0 -> ofm_data=-4.
- psum_in=2^30 on all channels -> ofm_data=32767 (output saturation). Accumulator holds 2^35-1 without wrapping.
- ofm_ready held low for 5 cycles during the last channel -> psum_ready=0 within the same cycle, ofm_data is held stable, and no pixel is lost or duplicated. Compare all 49 results against a model.
- start pulsed during ACCUM, then rst_n=0 for 1 cycle mid-channel 1 -> start is ignored; after reset all outputs are 0 and the state is IDLE. A fresh start yields a correct map unaffected by stale buffer data.
- NUM_CHANNEL=1, psum_in=pixel_index<<8, random ofm_ready -> ofm_data equals pixel_index for pixels 0..48, in order.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared types and arithmetic helpers for the eyeriss psum path.
package eyeriss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int OFM_SIDE   = 7;
  localparam int OFM_PIXELS = OFM_SIDE * OFM_SIDE;

  // Helpers work on a 64-bit signed carrier; callers keep the low w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat_to(a + b, w);
  endfunction

endpackage

// File: rtl/psum_buffer.sv
// OFM-sized accumulator storage: combinational read, synchronous write, shared address.
// Contents are deliberately not reset; channel 0 always overwrites.
module psum_buffer #(
  parameter int DEPTH = 49,
  parameter int WIDTH = 36,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk1,
  input  logic                    wr_en,
  input  logic [AW-1:0]           addr,
  input  logic signed [WIDTH-1:0] wr_dat,
  output logic signed [WIDTH-1:0] rd_dat
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk1) begin
    if (wr_en) mem_q[addr] <= wr_dat;
  end

  assign rd_dat = mem_q[addr];

endmodule

// File: rtl/psum_accumulator.sv
// Sums per-channel psums into an OFM buffer; last channel goes through ReLU/shift/saturate to a
// one-entry output register (1-cycle latency); output backpressure stalls psum_ready combinationally.
module psum_accumulator
  import eyeriss_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 36,
  parameter int NUM_CHANNEL = 3,
  parameter int OFM_SIZE    = OFM_SIDE,
  parameter int FRAC_BITS   = 8,
  parameter int RELU_EN     = 1
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  output logic                         ofm_valid,
  input  logic                         ofm_ready,
  output logic signed [DATA_WIDTH-1:0] ofm_data,
  output logic                         ofm_last,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   channel_cnt,
  output logic [9:0]                   pixel_cnt
);

  localparam int         NPIX     = OFM_SIZE * OFM_SIZE;
  localparam int         AW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [3:0] LAST_CH  = 4'(NUM_CHANNEL - 1);
  localparam logic [9:0] LAST_PIX = 10'(NPIX - 1);

  state_e                      state_q, state_d;
  logic [3:0]                  ch_q, ch_d;
  logic [9:0]                  pix_q, pix_d;
  logic                        ofm_vld_q, ofm_vld_d;
  logic                        ofm_last_q, ofm_last_d;
  logic signed [DATA_WIDTH-1:0] ofm_dat_q, ofm_dat_d;

  logic                        last_ch;
  logic                        in_xfer;
  logic                        wr_en;
  logic signed [ACC_WIDTH-1:0] rd_dat;
  logic signed [ACC_WIDTH-1:0] wr_dat;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] chan_val;
  logic signed [63:0]          rd_ext, in_ext, sum_ext, relu_ext, shr_ext, sat_ext;
  logic signed [DATA_WIDTH-1:0] out_pix;
  logic                        unused_hi_bits;

  psum_buffer #(
    .DEPTH (NPIX),
    .WIDTH (ACC_WIDTH),
    .AW    (AW)
  ) u_psum_buffer (
    .clk1   (clk1),
    .wr_en  (wr_en),
    .addr   (pix_q[AW-1:0]),
    .wr_dat (wr_dat),
    .rd_dat (rd_dat)
  );

  assign last_ch = (ch_q == LAST_CH);
  assign in_xfer = psum_valid && psum_ready;

  always_comb begin
    psum_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ACCUM: begin
        busy       = 1'b1;
        psum_ready = !last_ch || !ofm_vld_q || ofm_ready;
      end
      FLUSH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: saturating channel sum, then ReLU -> arithmetic shift -> output saturation.
  always_comb begin
    rd_ext   = {{(64-ACC_WIDTH){rd_dat[ACC_WIDTH-1]}}, rd_dat};
    in_ext   = {{(64-ACC_WIDTH){psum_in[ACC_WIDTH-1]}}, psum_in};
    sum_ext  = sat_add(rd_ext, in_ext, ACC_WIDTH);
    acc_sum  = sum_ext[ACC_WIDTH-1:0];
    chan_val = (ch_q == 4'd0) ? psum_in : acc_sum;
    wr_dat   = chan_val;
    wr_en    = in_xfer && !last_ch;
    relu_ext = {{(64-ACC_WIDTH){chan_val[ACC_WIDTH-1]}}, chan_val};
    if ((RELU_EN != 0) && (relu_ext < 0)) relu_ext = '0;
    shr_ext  = relu_ext >>> FRAC_BITS;
    sat_ext  = sat_to(shr_ext, DATA_WIDTH);
    out_pix  = sat_ext[DATA_WIDTH-1:0];
  end

  assign unused_hi_bits = ^{sum_ext[63:ACC_WIDTH], sat_ext[63:DATA_WIDTH]};

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    pix_d      = pix_q;
    ofm_vld_d  = ofm_vld_q;
    ofm_dat_d  = ofm_dat_q;
    ofm_last_d = ofm_last_q;
    if (ofm_vld_q && ofm_ready) ofm_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          ch_d    = 4'd0;
          pix_d   = 10'd0;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          if (last_ch) begin
            ofm_vld_d  = 1'b1;
            ofm_dat_d  = out_pix;
            ofm_last_d = (pix_q == LAST_PIX);
          end
          if (pix_q == LAST_PIX) begin
            pix_d = 10'd0;
            ch_d  = ch_q + 4'd1;
            if (last_ch) state_d = FLUSH;
          end else begin
            pix_d = pix_q + 10'd1;
          end
        end
      end
      FLUSH: begin
        if (!ofm_vld_q || ofm_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pix_q      <= '0;
      ofm_vld_q  <= 1'b0;
      ofm_dat_q  <= '0;
      ofm_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pix_q      <= pix_d;
      ofm_vld_q  <= ofm_vld_d;
      ofm_dat_q  <= ofm_dat_d;
      ofm_last_q <= ofm_last_d;
    end
  end

  assign ofm_valid   = ofm_vld_q;
  assign ofm_data    = ofm_dat_q;
  assign ofm_last    = ofm_last_q;
  assign channel_cnt = ch_q;
  assign pixel_cnt   = pix_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench: three instances (default, RELU off, single channel) checked against a plain-arithmetic model.
module tb_psum_accumulator;

  localparam int NP = 49;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic [2:0]  start, psum_valid, psum_ready, ofm_valid, ofm_last, busy, done;
  logic        ofm_ready = 1'b1;
  logic signed [35:0] psum_in     [3];
  logic signed [15:0] ofm_data    [3];
  logic [3:0]         channel_cnt [3];
  logic [9:0]         pixel_cnt   [3];

  longint      ps [3][NP];
  logic [16:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  int          cyc = 0;
  int          hold_at = -1000;
  bit          rdy_rand = 1'b0;
  bit          mon_en = 1'b0;
  logic        held_vld = 1'b0;
  logic signed [15:0] held_dat = '0;

  always #5 clk1 = ~clk1;

  psum_accumulator u_dut0 (
    .clk1(clk1), .rst_n(rst_n), .start(start[0]), .psum_valid(psum_valid[0]),
    .psum_ready(psum_ready[0]), .psum_in(psum_in[0]), .ofm_valid(ofm_valid[0]),
    .ofm_ready(ofm_ready), .ofm_data(ofm_data[0]), .ofm_last(ofm_last[0]), .busy(busy[0]),
    .done(done[0]), .channel_cnt(channel_cnt[0]), .pixel_cnt(pixel_cnt[0]));

  psum_accumulator #(.RELU_EN(0)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n), .start(start[1]), .psum_valid(psum_valid[1]),
    .psum_ready(psum_ready[1]), .psum_in(psum_in[1]), .ofm_valid(ofm_valid[1]),
    .ofm_ready(ofm_ready), .ofm_data(ofm_data[1]), .ofm_last(ofm_last[1]), .busy(busy[1]),
    .done(done[1]), .channel_cnt(channel_cnt[1]), .pixel_cnt(pixel_cnt[1]));

  psum_accumulator #(.NUM_CHANNEL(1)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n), .start(start[2]), .psum_valid(psum_valid[2]),
    .psum_ready(psum_ready[2]), .psum_in(psum_in[2]), .ofm_valid(ofm_valid[2]),
    .ofm_ready(ofm_ready), .ofm_data(ofm_data[2]), .ofm_last(ofm_last[2]), .busy(busy[2]),
    .done(done[2]), .channel_cnt(channel_cnt[2]), .pixel_cnt(pixel_cnt[2]));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint clampv(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Expected pixel: saturating sum over channels, optional ReLU, shift, clamp to 16 bits.
  function automatic longint ref_pix(input int p, input int nch, input bit relu);
    longint s;
    s = 0;
    for (int c = 0; c < nch; c++) s = clampv(s + ps[c][p], 36);
    if (relu && s < 0) s = 0;
    s = s >>> 8;
    return clampv(s, 16);
  endfunction

  always @(posedge clk1) cyc <= cyc + 1;

  always @(posedge clk1) begin
    #1;
    if (cyc >= hold_at && cyc < hold_at + 5) ofm_ready = 1'b0;
    else if (rdy_rand) ofm_ready = 1'($urandom_range(0, 1));
    else ofm_ready = 1'b1;
  end

  always @(negedge clk1) begin
    logic [16:0] e;
    if (rst_n && mon_en) begin
      if (held_vld && ofm_valid[cur]) chk("ofm_data_stable", ofm_data[cur], held_dat);
      if (ofm_valid[cur] && !ofm_ready && busy[cur]) chk("psum_ready_backpressure", psum_ready[cur], 0);
      if (ofm_valid[cur] && ofm_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: dut%0d data %0d with nothing expected", cur, ofm_data[cur]);
        end else begin
          e = exp_q.pop_front();
          chk("ofm_data", ofm_data[cur], longint'($signed(e[15:0])));
          chk("ofm_last", ofm_last[cur], longint'(e[16]));
        end
      end
      held_vld = ofm_valid[cur] && !ofm_ready;
      held_dat = ofm_data[cur];
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic chk_idle(input int u);
    chk("rst_ofm_valid", ofm_valid[u], 0);
    chk("rst_psum_ready", psum_ready[u], 0);
    chk("rst_busy", busy[u], 0);
    chk("rst_done", done[u], 0);
    chk("rst_ofm_data", ofm_data[u], 0);
    chk("rst_ofm_last", ofm_last[u], 0);
    chk("rst_channel_cnt", channel_cnt[u], 0);
    chk("rst_pixel_cnt", pixel_cnt[u], 0);
  endtask

  task automatic drive_map(input int u, input int nch, input bit relu,
                           input int hold_ch, input int abort_at, input int glitch_at);
    int n;
    int budget;
    bit acc;
    n = 0;
    if (abort_at < 0)
      for (int p = 0; p < NP; p++)
        exp_q.push_back({(p == NP - 1), 16'(ref_pix(p, nch, relu))});
    cur = u;
    @(posedge clk1); #1; start[u] = 1'b1;
    @(posedge clk1); #1; start[u] = 1'b0;
    chk("busy_after_start", busy[u], 1);
    for (int c = 0; c < nch; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (n == abort_at) begin
          psum_valid[u] = 1'b0;
          return;
        end
        if (n == glitch_at) begin
          psum_valid[u] = 1'b0;
          start[u] = 1'b1;
          @(posedge clk1); #1;
          start[u] = 1'b0;
        end
        if (c == hold_ch && p == 3) hold_at = cyc;
        if ($urandom_range(0, 3) == 0) begin
          psum_valid[u] = 1'b0;
          @(posedge clk1); #1;
        end
        psum_valid[u] = 1'b1;
        psum_in[u] = 36'(ps[c][p]);
        budget = 0;
        do begin
          @(negedge clk1);
          acc = psum_ready[u];
          @(posedge clk1); #1;
          budget++;
        end while (!acc && budget < 300);
        if (!acc) begin
          checks++;
          errors++;
          $display("FAIL psum_accept_timeout: dut%0d ch %0d pix %0d never accepted", u, c, p);
          psum_valid[u] = 1'b0;
          return;
        end
        n++;
      end
    end
    psum_valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int seen;
    int k;
    seen = 0;
    k = 0;
    while (seen == 0 && k < 400) begin
      @(negedge clk1);
      k++;
      if (done[u]) begin
        seen++;
        chk("busy_at_done", busy[u], 0);
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk1);
      if (done[u]) seen++;
    end
    chk("done_pulses", seen, 1);
    exp_q.delete();
  endtask

  task automatic fill_const(input longint a, input longint b, input longint c);
    for (int p = 0; p < NP; p++) begin
      ps[0][p] = a;
      ps[1][p] = b;
      ps[2][p] = c;
    end
  endtask

  task automatic fill_rand(input int shift);
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < NP; p++)
        ps[c][p] = (longint'($urandom) << shift) - (longint'(1) << (31 + shift));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    start = '0;
    psum_valid = '0;
    for (int u = 0; u < 3; u++) psum_in[u] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    for (int u = 0; u < 3; u++) chk_idle(u);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    fill_const(256, 256, 256);
    drive_map(0, 3, 1, -1, -1, -1);
    wait_done(0);

    fill_const(-1024, -1024, 1024);
    drive_map(0, 3, 1, -1, -1, -1);
    wait_done(0);
    drive_map(1, 3, 0, -1, -1, -1);
    wait_done(1);

    fill_const(longint'(1) << 30, longint'(1) << 30, longint'(1) << 30);
    drive_map(0, 3, 1, -1, -1, -1);
    wait_done(0);
    fill_const(-(longint'(1) << 35), -(longint'(1) << 35), -(longint'(1) << 35));
    drive_map(1, 3, 0, -1, -1, -1);
    wait_done(1);
    fill_const((longint'(1) << 35) - 1, (longint'(1) << 35) - 1, -((longint'(1) << 35) - 1));
    drive_map(1, 3, 0, -1, -1, -1);
    wait_done(1);

    fill_rand(-11 + 11);
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < NP; p++) ps[c][p] = ps[c][p] >>> 11;
    drive_map(0, 3, 1, 2, -1, -1);
    wait_done(0);
    rdy_rand = 1'b1;
    fill_rand(3);
    drive_map(1, 3, 0, 2, -1, -1);
    wait_done(1);

    fill_rand(0);
    drive_map(0, 3, 1, -1, 59, 20);
    @(negedge clk1);
    chk("start_ignored_channel", channel_cnt[0], 1);
    chk("start_ignored_pixel", pixel_cnt[0], 10);
    @(posedge clk1); #1;
    rst_n = 1'b0;
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(negedge clk1);
    chk_idle(0);
    fill_rand(0);
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < NP; p++) ps[c][p] = ps[c][p] >>> 6;
    drive_map(0, 3, 1, -1, -1, -1);
    wait_done(0);

    for (int p = 0; p < NP; p++) ps[0][p] = longint'(p) << 8;
    drive_map(2, 1, 1, -1, -1, -1);
    wait_done(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
